// File: rtl/psa_sub_seq.sv
// Multi-cycle partitioned saturating subtractor: four signed 4-bit lanes,
// one lane per cycle, with a start/busy/done handshake and per-lane saturation flags.
module psa_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Diff,
  output logic [3:0]  Sat
);

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned LIDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [LIDX_W-1:0]   lane, lane_n;
  logic [DATA_W-1:0]   a_q, a_n, b_q, b_n;
  logic [DATA_W-1:0]   diff_n;
  logic [LANES-1:0]    sat_n;
  logic                busy_n, done_n;

  logic [LANE_W-1:0]   a_lane, b_lane, res;
  logic [LANE_W:0]     d;
  logic                ovf;

  // Lane datapath: 5-bit signed difference, clamp when bits 4 and 3 disagree
  always_comb begin
    a_lane = a_q[{lane, 2'b00} +: LANE_W];
    b_lane = b_q[{lane, 2'b00} +: LANE_W];
    d      = {a_lane[LANE_W-1], a_lane} - {b_lane[LANE_W-1], b_lane};
    ovf    = d[LANE_W] ^ d[LANE_W-1];
    if (ovf) res = d[LANE_W] ? 4'b1000 : 4'b0111;
    else     res = d[LANE_W-1:0];
  end

  // Next-state and register-update logic
  always_comb begin
    state_n = state;
    lane_n  = lane;
    a_n     = a_q;
    b_n     = b_q;
    diff_n  = Diff;
    sat_n   = Sat;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = CALC;
          lane_n  = '0;
          a_n     = A;
          b_n     = B;
          diff_n  = '0;
          sat_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        diff_n[{lane, 2'b00} +: LANE_W] = res;
        sat_n[lane]                     = ovf;
        lane_n                          = lane + LIDX_W'(1);
        if (lane == LIDX_W'(LANES - 1)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == CALC);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      Diff  <= '0;
      Sat   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      lane  <= lane_n;
      a_q   <= a_n;
      b_q   <= b_n;
      Diff  <= diff_n;
      Sat   <= sat_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_psa_sub_seq.sv
// Directed bench for psa_sub_seq: vector table plus handshake and mid-operation reset sequences.
module tb_psa_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] Diff;
  logic [3:0]  Sat;

  int npass = 0;
  int ntotal = 0;

  psa_sub_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Sat   (Sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic [3:0]  sat;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One full operation from IDLE; inputs are scrambled after the accept edge.
  task automatic run_op(input vec_t v, input string tag);
    start = 1'b1;
    A = v.a;
    B = v.b;
    step();
    start = 1'b0;
    A = 16'hFFFF;
    B = 16'hFFFF;
    check({tag, " busy c0"}, 16'(busy), 16'd1);
    check({tag, " done c0"}, 16'(done), 16'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("%s busy c%0d", tag, i), 16'(busy), 16'd1);
      check($sformatf("%s done c%0d", tag, i), 16'(done), 16'd0);
    end
    step();
    check({tag, " done"}, 16'(done), 16'd1);
    check({tag, " busy in done"}, 16'(busy), 16'd0);
    check({tag, " diff"}, Diff, v.diff);
    check({tag, " sat"}, 16'(Sat), 16'(v.sat));
    step();
    check({tag, " done one cycle"}, 16'(done), 16'd0);
    check({tag, " diff hold"}, Diff, v.diff);
  endtask

  initial begin
    vec_t basic;
    vecs[0] = '{16'h1234, 16'h1111, 16'h0123, 4'h0};
    vecs[1] = '{16'h7777, 16'h8888, 16'h7777, 4'hF};
    vecs[2] = '{16'h8888, 16'h1111, 16'h8888, 4'hF};
    vecs[3] = '{16'h7805, 16'hF115, 16'h78F0, 4'b1100};
    vecs[4] = '{16'h0F7A, 16'h1787, 16'hF878, 4'b0011};
    vecs[5] = '{16'h4321, 16'h1234, 16'h31FD, 4'h0};
    basic = vecs[0];

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    step();
    step();
    rst = 1'b0;
    check("reset busy", 16'(busy), 16'd0);
    check("reset done", 16'(done), 16'd0);
    check("reset diff", Diff, 16'h0000);
    check("reset sat", 16'(Sat), 16'h0);

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // start held high: accepts only in IDLE/DONE, done after edges 4, 9, 14
    start = 1'b1;
    A = 16'h0001;
    B = 16'h0001;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c == 11) start = 1'b0;
      check($sformatf("hs done c%0d", c), 16'(done), 16'(c == 4 || c == 9 || c == 14));
      check($sformatf("hs busy c%0d", c), 16'(busy), 16'((c < 14) && (c % 5 != 4)));
      if (c == 4 || c == 9 || c == 14) check($sformatf("hs diff c%0d", c), Diff, 16'h0000);
    end

    // reset asserted at the edge that would compute lane 2
    start = 1'b1;
    A = 16'h7777;
    B = 16'h8888;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", 16'(busy), 16'd0);
    check("midrst done", 16'(done), 16'd0);
    check("midrst diff", Diff, 16'h0000);
    check("midrst sat", 16'(Sat), 16'h0);
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("midrst no done c%0d", c), 16'(done), 16'd0);
      check($sformatf("midrst idle busy c%0d", c), 16'(busy), 16'd0);
    end
    run_op(basic, "post_rst");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
